lc3_pipe_controller: RTL and testbench

//  Pipeline controller for the LC3 core. Produces the signal set carried on the control_out bus:

---
 rtl/lc3_pipe_controller.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller
//   Pipeline controller for the LC3 core: stage enables, ALU/memory bypass
//   selects, data-memory access state (mem_state) and branch redirect.
//   Optional memory-access watchdog is compiled in when the macro
//   LC3_CTRL_TIMEOUT_EN is defined (adds the mem_timeout port).
module lc3_pipe_controller #(
   parameter int CTRL_STALL_CYCLES = 3,
   parameter int MEM_TIMEOUT       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        complete_data,
   input  logic        complete_instr,
   input  logic [15:0] IMem_dout,
   input  logic [15:0] IR,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  NZP,
   input  logic [2:0]  psr,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic        bypass_mem_1,
   output logic        bypass_mem_2,
   output logic [1:0]  mem_state,
   output logic        br_taken
`ifdef LC3_CTRL_TIMEOUT_EN
   ,
   output logic        mem_timeout
`endif
);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   localparam logic [1:0] MS_RD   = 2'b00;
   localparam logic [1:0] MS_IND  = 2'b01;
   localparam logic [1:0] MS_WR   = 2'b10;
   localparam logic [1:0] MS_IDLE = 2'b11;

   // enable vector bit positions: {updatePC, fetch, decode, execute, writeback}
   localparam int EN_UPC   = 4;
   localparam int EN_FETCH = 3;
   localparam int EN_DEC   = 2;
   localparam int EN_EXE   = 1;
   localparam int EN_WB    = 0;

   localparam logic [2:0] STALL_LOAD = 3'(CTRL_STALL_CYCLES);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_RUN    = 2'd1,
      ST_MEM    = 2'd2,
      ST_CSTALL = 2'd3
   } state_t;

   function automatic logic op_is_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
   endfunction

   function automatic logic op_is_load(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
   endfunction

   // first access phase of a memory instruction; indirect forms start with the pointer read
   function automatic logic [1:0] mem_first(input logic [3:0] op);
      case (op)
         OP_LD, OP_LDR:   return MS_RD;
         OP_ST, OP_STR:   return MS_WR;
         OP_LDI, OP_STI:  return MS_IND;
         default:         return MS_IDLE;
      endcase
   endfunction

   state_t      state_r, state_s;
   logic [4:0]  en_r, en_s;
   logic [1:0]  mem_state_r, mem_state_s;
   logic [2:0]  stall_cnt_r, stall_cnt_s;
   logic        is_store_r, is_store_s;
   logic        pend_r, pend_s;
   logic        ret_r, ret_s;
   logic        ret_load_r, ret_load_s;

   logic [3:0]  op_x_s, op_d_s, op_f_s;
   logic        mem_go_s, ctl_go_s;
   logic        hit1_s, hit2_s;
   logic        unused_s;

`ifdef LC3_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
   logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
   logic          tmo_pulse_r, tmo_pulse_s;
`endif

   assign op_x_s = IR_Exec[15:12];
   assign op_d_s = IR[15:12];
   assign op_f_s = IMem_dout[15:12];

   // fields of the instruction words that the controller never looks at
   assign unused_s = ^{complete_instr, IMem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};

   // a memory instruction starts its access once, on its first cycle in execute
   assign mem_go_s = en_r[EN_EXE] && op_is_mem(op_x_s) && !ret_r;
   assign ctl_go_s = en_r[EN_FETCH] && ((op_f_s == OP_BR) || (op_f_s == OP_JMP));

   function automatic logic op_is_mem(input logic [3:0] op);
      return op_is_load(op) || op_is_store(op);
   endfunction

   // operand match between the executing destination and the decoding sources
   assign hit1_s = (op_is_alu(op_d_s) || (op_d_s == OP_LDR) || (op_d_s == OP_STR) || (op_d_s == OP_JMP))
                   && (IR_Exec[11:9] == IR[8:6]);
   assign hit2_s = ((op_d_s == OP_ADD) || (op_d_s == OP_AND)) && !IR[5]
                   && (IR_Exec[11:9] == IR[2:0]);

   // next-state and next registered outputs of the pipeline FSM
   always_comb begin
      state_s     = state_r;
      en_s        = en_r;
      mem_state_s = mem_state_r;
      stall_cnt_s = stall_cnt_r;
      is_store_s  = is_store_r;
      pend_s      = pend_r;
      ret_s       = 1'b0;
      ret_load_s  = 1'b0;
`ifdef LC3_CTRL_TIMEOUT_EN
      tmo_cnt_s   = tmo_cnt_r;
      tmo_pulse_s = 1'b0;
`endif
      case (state_r)
         ST_FILL: begin
            en_s = {1'b1, 1'b1, 1'b1, en_r[EN_DEC], en_r[EN_EXE]};
            if (en_r[EN_EXE]) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_RUN: begin
            if (mem_go_s) begin
               state_s     = ST_MEM;
               en_s        = 5'b00000;
               mem_state_s = mem_first(op_x_s);
               is_store_s  = op_is_store(op_x_s);
               pend_s      = ctl_go_s;      // branch already in decode waits for the access
`ifdef LC3_CTRL_TIMEOUT_EN
               tmo_cnt_s   = {TW{1'b0}};
`endif
            end else if (ctl_go_s) begin
               state_s     = ST_CSTALL;
               stall_cnt_s = STALL_LOAD;
               en_s        = {STALL_LOAD == 3'd1, 1'b0, 1'b1, en_r[EN_DEC], en_r[EN_EXE]};
            end else begin
               en_s = 5'b11111;
            end
         end
         ST_MEM: begin
            en_s = 5'b00000;
            if (complete_data) begin
`ifdef LC3_CTRL_TIMEOUT_EN
               tmo_cnt_s = {TW{1'b0}};
`endif
               if (mem_state_r == MS_IND) begin
                  mem_state_s = is_store_r ? MS_WR : MS_RD;
               end else if (mem_state_r == MS_IDLE) begin
                  state_s = ST_RUN;
                  en_s    = 5'b11111;
               end else begin
                  // return cycle: stores skip writeback for this one cycle
                  mem_state_s = MS_IDLE;
                  ret_s       = 1'b1;
                  ret_load_s  = !is_store_r;
                  pend_s      = 1'b0;
                  if (pend_r) begin
                     state_s     = ST_CSTALL;
                     stall_cnt_s = STALL_LOAD;
                     en_s        = {STALL_LOAD == 3'd1, 1'b0, 1'b1, 1'b1, !is_store_r};
                  end else begin
                     state_s = ST_RUN;
                     en_s    = {4'b1111, !is_store_r};
                  end
               end
            end else begin
`ifdef LC3_CTRL_TIMEOUT_EN
               if (tmo_cnt_r == TMO_LAST) begin
                  state_s     = ST_RUN;
                  en_s        = 5'b11111;
                  mem_state_s = MS_IDLE;
                  pend_s      = 1'b0;
                  ret_s       = 1'b1;
                  tmo_pulse_s = 1'b1;
                  tmo_cnt_s   = {TW{1'b0}};
               end else begin
                  tmo_cnt_s = tmo_cnt_r + TW'(1);
               end
`else
               state_s = ST_MEM;
`endif
            end
         end
         ST_CSTALL: begin
            if (stall_cnt_r <= 3'd1) begin
               state_s     = ST_RUN;
               stall_cnt_s = 3'd0;
               en_s        = 5'b11111;
            end else begin
               stall_cnt_s = stall_cnt_r - 3'd1;
               en_s        = {stall_cnt_r == 3'd2, 1'b0, 1'b0, en_r[EN_DEC], en_r[EN_EXE]};
            end
         end
         default: begin
            state_s     = ST_FILL;
            en_s        = 5'b11000;
            mem_state_s = MS_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_FILL;
         en_r        <= 5'b11000;
         mem_state_r <= MS_IDLE;
         stall_cnt_r <= 3'd0;
         is_store_r  <= 1'b0;
         pend_r      <= 1'b0;
         ret_r       <= 1'b0;
         ret_load_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         en_r        <= en_s;
         mem_state_r <= mem_state_s;
         stall_cnt_r <= stall_cnt_s;
         is_store_r  <= is_store_s;
         pend_r      <= pend_s;
         ret_r       <= ret_s;
         ret_load_r  <= ret_load_s;
      end
   end

`ifdef LC3_CTRL_TIMEOUT_EN
   // memory watchdog counter and abort pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_r   <= {TW{1'b0}};
         tmo_pulse_r <= 1'b0;
      end else begin
         tmo_cnt_r   <= tmo_cnt_s;
         tmo_pulse_r <= tmo_pulse_s;
      end
   end

   assign mem_timeout = tmo_pulse_r;
`endif

   // forwarding selects; memory forwarding wins and only in a load's return cycle
   always_comb begin
      bypass_alu_1 = 1'b0;
      bypass_alu_2 = 1'b0;
      bypass_mem_1 = 1'b0;
      bypass_mem_2 = 1'b0;
      if (en_r[EN_EXE]) begin
         bypass_mem_1 = ret_load_r && op_is_load(op_x_s) && hit1_s;
         bypass_mem_2 = ret_load_r && op_is_load(op_x_s) && hit2_s;
         bypass_alu_1 = op_is_alu(op_x_s) && hit1_s && !bypass_mem_1;
         bypass_alu_2 = op_is_alu(op_x_s) && hit2_s && !bypass_mem_2;
      end else begin
         bypass_alu_1 = 1'b0;
         bypass_alu_2 = 1'b0;
         bypass_mem_1 = 1'b0;
         bypass_mem_2 = 1'b0;
      end
   end

   // PC redirect: conditional BR on matching condition codes, JMP always
   always_comb begin
      br_taken = 1'b0;
      if (op_x_s == OP_JMP) begin
         br_taken = 1'b1;
      end else if (op_x_s == OP_BR) begin
         br_taken = |(NZP & psr);
      end else begin
         br_taken = 1'b0;
      end
   end

   assign enable_updatePC  = en_r[EN_UPC];
   assign enable_fetch     = en_r[EN_FETCH];
   assign enable_decode    = en_r[EN_DEC];
   assign enable_execute   = en_r[EN_EXE];
   assign enable_writeback = en_r[EN_WB];
   assign mem_state        = mem_state_r;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller: vector table for branch/bypass
// decode plus hand sequences for fill, memory, stall and reset corners.
module tb_lc3_pipe_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        complete_data;
   logic        complete_instr;
   logic [15:0] IMem_dout;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  NZP;
   logic [2:0]  psr;
   logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
   logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
   logic [1:0]  mem_state;
   logic        br_taken;
`ifdef LC3_CTRL_TIMEOUT_EN
   logic        mem_timeout;
`endif

   localparam logic [15:0] SAFE_X = 16'hF025;   // TRAP: no memory, no branch, no write
   localparam logic [15:0] SAFE_F = 16'h5020;   // AND: not a control instruction

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] ir_exec;
      logic [15:0] ir;
      logic [2:0]  nzp;
      logic [2:0]  psr;
      logic        br;
      logic        a1;
      logic        a2;
   } vec_t;

   vec_t vecs [14];

   lc3_pipe_controller dut (
      .clk              (clk),
      .rst              (rst),
      .complete_data    (complete_data),
      .complete_instr   (complete_instr),
      .IMem_dout        (IMem_dout),
      .IR               (IR),
      .IR_Exec          (IR_Exec),
      .NZP              (NZP),
      .psr              (psr),
      .enable_updatePC  (enable_updatePC),
      .enable_fetch     (enable_fetch),
      .enable_decode    (enable_decode),
      .enable_execute   (enable_execute),
      .enable_writeback (enable_writeback),
      .bypass_alu_1     (bypass_alu_1),
      .bypass_alu_2     (bypass_alu_2),
      .bypass_mem_1     (bypass_mem_1),
      .bypass_mem_2     (bypass_mem_2),
      .mem_state        (mem_state),
      .br_taken         (br_taken)
`ifdef LC3_CTRL_TIMEOUT_EN
      ,
      .mem_timeout      (mem_timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] en_vec();
      return {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
   endfunction

   function automatic logic [3:0] byp_vec();
      return {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_state(input string name, input logic [4:0] en, input logic [1:0] ms);
      check({name, "_en"}, 16'(en_vec()), 16'(en));
      check({name, "_ms"}, 16'(mem_state), 16'(ms));
   endtask

   initial begin
`ifdef LC3_CTRL_TIMEOUT_EN
      int tk;
`endif
      vecs[0]  = '{16'h0400, 16'h12C3, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{16'h0400, 16'h12C3, 3'b010, 3'b100, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{16'h0000, 16'h12C3, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{16'hC1C0, 16'h12C3, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{16'h1642, 16'h12C3, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{16'h1642, 16'h12E3, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{16'h5420, 16'h7A80, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{16'h993F, 16'hC100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{16'h1642, 16'h1285, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{16'h1642, 16'h2CC0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{16'h3600, 16'h12C3, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{16'h6640, 16'h12C3, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{16'h1642, 16'h50C3, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{16'h0201, 16'h12C3, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};

      rst = 1'b0; complete_data = 1'b0; complete_instr = 1'b0;
      IMem_dout = SAFE_F; IR = SAFE_X; IR_Exec = SAFE_X; NZP = 3'b000; psr = 3'b000;

      // reset and pipeline fill
      step();
      check_state("reset", 5'b11000, 2'b11);
      step();
      rst = 1'b1;
      check_state("fill0", 5'b11000, 2'b11);
      step();
      check_state("fill1", 5'b11100, 2'b11);
      step();
      check_state("fill2", 5'b11110, 2'b11);
      step();
      check_state("fill3", 5'b11111, 2'b11);

      // stray completion in idle is ignored
      complete_data = 1'b1;
      step();
      complete_data = 1'b0;
      check_state("stray_cd", 5'b11111, 2'b11);

      // vector table: branch decision and bypass selects
      for (int i = 0; i < 14; i++) begin
         IR_Exec = vecs[i].ir_exec; IR = vecs[i].ir; NZP = vecs[i].nzp; psr = vecs[i].psr;
         #1;
         check($sformatf("br_taken_v%0d", i), 16'(br_taken), 16'(vecs[i].br));
         check($sformatf("bypass_v%0d", i), 16'(byp_vec()), 16'({vecs[i].a1, vecs[i].a2, 2'b00}));
         IR_Exec = SAFE_X; IR = SAFE_X;
         step();
      end
      check_state("post_table", 5'b11111, 2'b11);

      // LDI: pointer read then data read, forward in the return cycle
      IR_Exec = 16'hA600; IR = 16'h12C3;
      #1;
      check("ldi_c0_byp", 16'(byp_vec()), 16'h0);
      step();
      check_state("ldi_c1", 5'b00000, 2'b01);
      check("ldi_c1_byp", 16'(byp_vec()), 16'h0);
      step();
      check_state("ldi_c2", 5'b00000, 2'b01);
      complete_data = 1'b1;
      step();
      complete_data = 1'b0;
      check_state("ldi_c3", 5'b00000, 2'b00);
      step();
      check_state("ldi_c4", 5'b00000, 2'b00);
      complete_data = 1'b1;
      step();
      complete_data = 1'b0;
      check_state("ldi_c5", 5'b11111, 2'b11);
      check("ldi_c5_byp", 16'(byp_vec()), 16'(4'b0011));
      step();
      check_state("ldi_c6", 5'b11111, 2'b11);
      check("ldi_c6_byp", 16'(byp_vec()), 16'h0);
      IR_Exec = SAFE_X; IR = SAFE_X;
      step();

      // ST: write then return with writeback held off one cycle
      IR_Exec = 16'h3600;
      step();
      check_state("st_c1", 5'b00000, 2'b10);
      complete_data = 1'b1;
      step();
      complete_data = 1'b0;
      IR_Exec = SAFE_X;
      check_state("st_ret", 5'b11110, 2'b11);
      step();
      check_state("st_run", 5'b11111, 2'b11);

      // control stall after BR enters decode
      IMem_dout = 16'h0402;
      step();
      IMem_dout = SAFE_F;
      check_state("cs_s1", 5'b00111, 2'b11);
      step();
      check_state("cs_s2", 5'b00011, 2'b11);
      step();
      check_state("cs_s3", 5'b10001, 2'b11);
      step();
      check_state("cs_run", 5'b11111, 2'b11);

      // LD coinciding with JMP entering decode: access first, stall after
      IR_Exec = 16'h2600; IMem_dout = 16'hC1C0;
      step();
      IMem_dout = SAFE_F;
      check_state("co_mem", 5'b00000, 2'b00);
      complete_data = 1'b1;
      step();
      complete_data = 1'b0;
      IR_Exec = SAFE_X;
      check_state("co_s1", 5'b00111, 2'b11);
      step();
      check_state("co_s2", 5'b00011, 2'b11);
      step();
      check_state("co_s3", 5'b10001, 2'b11);
      step();
      check_state("co_run", 5'b11111, 2'b11);

      // reset during a memory wait
      IR_Exec = 16'h3600;
      step();
      check_state("rm_mem", 5'b00000, 2'b10);
      rst = 1'b0; IR_Exec = SAFE_X;
      step();
      check_state("rm_rst", 5'b11000, 2'b11);
      rst = 1'b1;
      step(); step(); step();
      check_state("rm_run", 5'b11111, 2'b11);

      // reset during a control stall
      IMem_dout = 16'h0402;
      step();
      IMem_dout = SAFE_F;
      check_state("rs_s1", 5'b00111, 2'b11);
      rst = 1'b0;
      step();
      check_state("rs_rst", 5'b11000, 2'b11);
      rst = 1'b1;
      step(); step(); step();
      check_state("rs_run", 5'b11111, 2'b11);

`ifdef LC3_CTRL_TIMEOUT_EN
      // watchdog abort of a store that never completes
      IR_Exec = 16'h3600;
      step();
      IR_Exec = SAFE_X;
      tk = -1;
      for (int k = 0; k < 40; k++) begin
         if (mem_timeout === 1'b1) begin
            tk = k;
            break;
         end
         step();
      end
      check("tmo_cycle", 16'(tk), 16'd16);
      check_state("tmo_abort", 5'b11111, 2'b11);
      step();
      check("tmo_pulse_end", 16'(mem_timeout), 16'h0);

      // reset in the middle of the watchdog wait
      IR_Exec = 16'h3600;
      step();
      IR_Exec = SAFE_X;
      step(); step(); step(); step();
      rst = 1'b0;
      step();
      check_state("tmo_rst", 5'b11000, 2'b11);
      check("tmo_rst_pulse", 16'(mem_timeout), 16'h0);
      rst = 1'b1;
      step(); step(); step();
      check_state("tmo_rst_run", 5'b11111, 2'b11);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
